// File: rtl/operand_fetch_scoreboard.sv
// Operand fetch stage: reads rs/rt from the register file (with writeback bypass, r0 = 0)
// into a one-entry output register, and stalls RAW/WAW hazards against outstanding writes.
module operand_fetch_scoreboard #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [4:0]            issue_rs,
  input  logic [4:0]            issue_rt,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_rd_we,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [4:0]            rf_readRegA,
  output logic [4:0]            rf_readRegB,
  input  logic [DATA_WIDTH-1:0] rf_dataA,
  input  logic [DATA_WIDTH-1:0] rf_dataB,
  output logic                  rf_writeEnable,
  output logic [4:0]            rf_writeReg,
  output logic [DATA_WIDTH-1:0] rf_writeData,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [4:0]            op_rd,
  output logic                  op_rd_we,
  output logic                  sb_error
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Valid never waits on ready; issue_ready may look at the issue_* fields combinationally,
  // and op_* hold stable while op_valid && !op_ready.

  localparam logic [5:0] MaxPend = 6'(MAX_PENDING);

  logic [31:0]           pending;
  logic [31:0]           pendingNext;
  logic [31:0]           clrVec;
  logic [31:0]           setVec;
  logic [31:0]           hzVec;
  logic [5:0]            count;
  logic [5:0]            countBase;
  logic [5:0]            countNext;
  logic                  wbHit;
  logic                  wbStray;
  logic                  capFull;
  logic                  slotFree;
  logic                  accept;
  logic                  setEn;
  logic [DATA_WIDTH-1:0] opANext;
  logic [DATA_WIDTH-1:0] opBNext;

  assign rf_readRegA    = issue_rs;
  assign rf_readRegB    = issue_rt;
  assign rf_writeEnable = wb_valid;
  assign rf_writeReg    = wb_reg;
  assign rf_writeData   = wb_data;

  always_comb begin
    clrVec  = '0;
    setVec  = '0;
    wbHit   = wb_valid && pending[wb_reg];
    wbStray = wb_valid && (wb_reg != 5'd0) && !pending[wb_reg];
    if (wbHit) begin
      clrVec[wb_reg] = 1'b1;
    end
    // A register retiring this very cycle is no longer a hazard; r0 never is.
    hzVec     = pending & ~clrVec & ~32'h1;
    countBase = count - {5'b0, wbHit};
    capFull   = issue_rd_we && (issue_rd != 5'd0) && (countBase == MaxPend);
    slotFree  = !op_valid || op_ready;

    issue_ready = slotFree && !hzVec[issue_rs] && !hzVec[issue_rt] &&
                  !(issue_rd_we && hzVec[issue_rd]) && !capFull;
    accept = issue_valid && issue_ready;
    setEn  = accept && issue_rd_we && (issue_rd != 5'd0);
    if (setEn) begin
      setVec[issue_rd] = 1'b1;
    end
    // Set after clear so a same-cycle retire and re-issue of one register leaves it pending.
    pendingNext = (pending & ~clrVec) | setVec;
    countNext   = countBase + {5'b0, setEn};

    // The regfile returns garbage when read and write collide, so bypass wins over rf data.
    if (issue_rs == 5'd0) begin
      opANext = '0;
    end else if (wb_valid && (wb_reg == issue_rs)) begin
      opANext = wb_data;
    end else begin
      opANext = rf_dataA;
    end
    if (issue_rt == 5'd0) begin
      opBNext = '0;
    end else if (wb_valid && (wb_reg == issue_rt)) begin
      opBNext = wb_data;
    end else begin
      opBNext = rf_dataB;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      pending  <= '0;
      count    <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
      op_rd_we <= 1'b0;
      sb_error <= 1'b0;
    end else begin
      pending <= pendingNext;
      count   <= countNext;
      if (accept) begin
        op_valid <= 1'b1;
        op_a     <= opANext;
        op_b     <= opBNext;
        op_rd    <= issue_rd;
        op_rd_we <= issue_rd_we;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
      if (wbStray) begin
        sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// Self-checking bench for operand_fetch_scoreboard: directed scenarios plus randomized traffic
// checked against a set-of-pending-registers reference model.
module tb_operand_fetch_scoreboard;

  localparam int DW   = 32;
  localparam int MAXP = 8;

  logic          clock = 1'b0;
  logic          ctrl_reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [4:0]    issue_rs, issue_rt, issue_rd;
  logic          issue_rd_we;
  logic          wb_valid;
  logic [4:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic [4:0]    rf_readRegA, rf_readRegB;
  logic [DW-1:0] rf_dataA, rf_dataB;
  logic          rf_writeEnable;
  logic [4:0]    rf_writeReg;
  logic [DW-1:0] rf_writeData;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a, op_b;
  logic [4:0]    op_rd;
  logic          op_rd_we;
  logic          sb_error;

  int errors = 0;
  int checks = 0;

  // Register file environment: read/write collisions return junk.
  logic [DW-1:0] rfMem [32];
  assign rf_dataA = (rf_writeEnable && rf_writeReg == rf_readRegA) ? 32'hDEAD_BEEF : rfMem[rf_readRegA];
  assign rf_dataB = (rf_writeEnable && rf_writeReg == rf_readRegB) ? 32'hDEAD_BEEF : rfMem[rf_readRegB];

  // Reference model state.
  bit            mPend [32];
  bit            mOpValid;
  bit            mErr;
  logic [DW-1:0] mOpA, mOpB;
  logic [4:0]    mOpRd;
  bit            mOpWe;

  always #5 clock = ~clock;

  operand_fetch_scoreboard #(.DATA_WIDTH(DW), .MAX_PENDING(MAXP)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_readRegA(rf_readRegA), .rf_readRegB(rf_readRegB),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .rf_writeEnable(rf_writeEnable), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_we(op_rd_we),
    .sb_error(sb_error)
  );

  // ---------------- reference model ----------------
  function automatic bit blocked(input logic [4:0] r);
    // A pending register is free again if this cycle's writeback targets it.
    return (r != 5'd0) && mPend[r] && !(wb_valid && wb_reg == r);
  endfunction

  function automatic bit modelReady();
    int outstanding = 0;
    for (int i = 0; i < 32; i++) if (mPend[i]) outstanding++;
    if (wb_valid && mPend[wb_reg]) outstanding--;
    if (mOpValid && !op_ready) return 1'b0;
    if (blocked(issue_rs) || blocked(issue_rt)) return 1'b0;
    if (issue_rd_we && blocked(issue_rd)) return 1'b0;
    if (issue_rd_we && issue_rd != 5'd0 && outstanding >= MAXP) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] modelOperand(input logic [4:0] r);
    if (r == 5'd0) return '0;
    if (wb_valid && wb_reg == r) return wb_data;
    return rfMem[r];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    mOpValid = 1'b0; mErr = 1'b0;
    mOpA = '0; mOpB = '0; mOpRd = '0; mOpWe = 1'b0;
  endtask

  // Advance one clock: capture what the model expects, clock, then update model and regfile.
  task automatic advance();
    bit            acc, consume, wbe;
    logic [DW-1:0] nA, nB, wd;
    logic [4:0]    wr, rd;
    bit            rdWe, wbv;
    logic [4:0]    wbr;
    acc = issue_valid && modelReady();
    consume = op_ready;
    nA = modelOperand(issue_rs);
    nB = modelOperand(issue_rt);
    rd = issue_rd; rdWe = issue_rd_we;
    wbv = wb_valid; wbr = wb_reg;
    wbe = wb_valid; wr = wb_reg; wd = wb_data;
    @(posedge clock);
    #1;
    if (wbv && wbr != 5'd0) begin
      if (mPend[wbr]) mPend[wbr] = 1'b0;
      else mErr = 1'b1;
    end
    if (acc && rdWe && rd != 5'd0) mPend[rd] = 1'b1;
    if (acc) begin
      mOpValid = 1'b1; mOpA = nA; mOpB = nB; mOpRd = rd; mOpWe = rdWe;
    end else if (consume) begin
      mOpValid = 1'b0;
    end
    if (wbe) rfMem[wr] = wd;
  endtask

  // ---------------- drivers ----------------
  task automatic setIssue(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input bit we);
    issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_rd_we = we;
  endtask

  task automatic setWb(input bit v, input logic [4:0] r, input logic [DW-1:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ctrl_reset = 1'b1;
    setIssue(0, 0, 0, 0, 0);
    setWb(0, 0, '0);
    op_ready = 1'b1;
    modelClear();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (op_valid !== 1'b0 || op_a !== '0 || op_b !== '0 || op_rd !== 5'd0 || op_rd_we !== 1'b0 || sb_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b a=%h b=%h rd=%0d we=%b err=%b, expected all zero",
               op_valid, op_a, op_b, op_rd, op_rd_we, sb_error);
    end
    ctrl_reset = 1'b0;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", issue_ready);
    end
    advance();
  endtask

  task automatic test_basic_fetch();
    rfMem[3] = 32'h11; rfMem[4] = 32'h22;
    setIssue(1, 3, 4, 0, 0);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1 || rf_readRegA !== 5'd3 || rf_readRegB !== 5'd4) begin
      errors++;
      $display("FAIL fetch_issue: got ready=%b regA=%0d regB=%0d expected 1/3/4", issue_ready, rf_readRegA, rf_readRegB);
    end
    advance();
    setIssue(0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h22) begin
      errors++;
      $display("FAIL fetch_ops: got valid=%b a=%h b=%h expected 1/11/22", op_valid, op_a, op_b);
    end
    advance();
  endtask

  task automatic test_raw_bypass();
    setIssue(1, 1, 2, 5, 1);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_writer_issue: got %b expected 1", issue_ready);
    end
    advance();
    setIssue(1, 5, 0, 6, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall: got ready=%b expected 0 (cycle %0d)", issue_ready, i);
      end
      advance();
    end
    setWb(1, 5, 32'hAB);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1 || rf_writeEnable !== 1'b1 || rf_writeReg !== 5'd5 || rf_writeData !== 32'hAB) begin
      errors++;
      $display("FAIL raw_release: got ready=%b we=%b reg=%0d data=%h expected 1/1/5/ab",
               issue_ready, rf_writeEnable, rf_writeReg, rf_writeData);
    end
    advance();
    setIssue(0, 0, 0, 0, 0);
    setWb(0, 0, '0);
    @(negedge clock);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 32'hAB || op_rd !== 5'd6 || op_rd_we !== 1'b0) begin
      errors++;
      $display("FAIL raw_bypass: got valid=%b a=%h rd=%0d we=%b expected 1/ab/6/0", op_valid, op_a, op_rd, op_rd_we);
    end
    advance();
  endtask

  task automatic test_r0_zero();
    rfMem[0] = 32'hFFFF_FFFF;
    setIssue(1, 0, 0, 0, 1);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_issue: got %b expected 1", issue_ready);
    end
    advance();
    setIssue(0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (op_a !== '0 || op_b !== '0 || op_rd_we !== 1'b1 || op_rd !== 5'd0) begin
      errors++;
      $display("FAIL r0_zero: got a=%h b=%h we=%b rd=%0d expected 0/0/1/0", op_a, op_b, op_rd_we, op_rd);
    end
    advance();
  endtask

  task automatic test_pending_limit();
    for (int r = 1; r <= 8; r++) begin
      setIssue(1, 0, 0, 5'(r), 1);
      @(negedge clock);
      checks++;
      if (issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL limit_fill: got ready=%b expected 1 for rd=%0d", issue_ready, r);
      end
      advance();
    end
    setIssue(1, 0, 0, 9, 1);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL limit_stall: got %b expected 0", issue_ready);
    end
    advance();
    setWb(1, 1, 32'h100);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL limit_wb_release: got %b expected 1", issue_ready);
    end
    advance();
    setWb(0, 0, '0);
    setIssue(1, 0, 0, 10, 1);
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL limit_still_full: got %b expected 0", issue_ready);
    end
    advance();
    setIssue(0, 0, 0, 0, 0);
    for (int r = 2; r <= 9; r++) begin
      setWb(1, 5'(r), 32'(r * 3));
      advance();
    end
    setWb(0, 0, '0);
    @(negedge clock);
    checks++;
    if (sb_error !== 1'b0) begin
      errors++;
      $display("FAIL limit_drain_err: got sb_error=%b expected 0", sb_error);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    rfMem[11] = 32'h1111; rfMem[12] = 32'h1212;
    op_ready = 1'b1;
    setIssue(1, 11, 12, 0, 0);
    advance();
    op_ready = 1'b0;
    setIssue(1, 12, 11, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (op_valid !== 1'b1 || op_a !== 32'h1111 || op_b !== 32'h1212 || issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got valid=%b a=%h b=%h ready=%b expected 1/1111/1212/0",
                 i, op_valid, op_a, op_b, issue_ready);
      end
      advance();
    end
    op_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b expected 1", issue_ready);
    end
    advance();
    setIssue(1, 11, 11, 0, 0);
    @(negedge clock);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 32'h1212 || op_b !== 32'h1111 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b a=%h b=%h ready=%b expected 1/1212/1111/1",
               op_valid, op_a, op_b, issue_ready);
    end
    advance();
    setIssue(0, 0, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (op_valid !== 1'b1 || op_a !== 32'h1111 || op_b !== 32'h1111) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b a=%h b=%h expected 1/1111/1111", op_valid, op_a, op_b);
    end
    advance();
  endtask

  task automatic test_stray_wb_and_reset();
    op_ready = 1'b1;
    setIssue(1, 0, 0, 6, 1);
    advance();
    op_ready = 1'b0;
    setIssue(0, 0, 0, 0, 0);
    setWb(1, 9, 32'h99);
    @(negedge clock);
    checks++;
    if (sb_error !== 1'b0) begin
      errors++;
      $display("FAIL stray_before: got sb_error=%b expected 0", sb_error);
    end
    advance();
    setWb(0, 0, '0);
    setIssue(1, 6, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (sb_error !== 1'b1 || issue_ready !== 1'b0 || op_valid !== 1'b1) begin
      errors++;
      $display("FAIL stray_after: got err=%b ready=%b valid=%b expected 1/0/1", sb_error, issue_ready, op_valid);
    end
    #2;
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if (op_valid !== 1'b0 || op_a !== '0 || op_b !== '0 || op_rd !== 5'd0 || op_rd_we !== 1'b0 || sb_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b a=%h b=%h rd=%0d we=%b err=%b expected all zero",
               op_valid, op_a, op_b, op_rd, op_rd_we, sb_error);
    end
    modelClear();
    #1;
    ctrl_reset = 1'b0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_clears_pending: got ready=%b expected 1", issue_ready);
    end
    advance();
    op_ready = 1'b1;
    setIssue(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [4:0] pendList[$];
    for (int cyc = 0; cyc < 400; cyc++) begin
      setIssue(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
               5'($urandom_range(0, 12)), ($urandom_range(0, 2) != 0));
      op_ready = ($urandom_range(0, 3) != 0);
      pendList.delete();
      for (int i = 1; i < 32; i++) if (mPend[i]) pendList.push_back(5'(i));
      if ($urandom_range(0, 9) < 4) begin
        if (pendList.size() > 0 && $urandom_range(0, 19) != 0)
          setWb(1, pendList[$urandom_range(0, pendList.size() - 1)], $urandom);
        else
          setWb(1, 5'($urandom_range(0, 12)), $urandom);
      end else begin
        setWb(0, 0, '0);
      end
      @(negedge clock);
      checks++;
      if (issue_ready !== modelReady()) begin
        errors++;
        $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, issue_ready, modelReady());
      end
      checks++;
      if (op_valid !== mOpValid || sb_error !== mErr) begin
        errors++;
        $display("FAIL rand_state: cycle %0d got valid=%b err=%b expected %b/%b", cyc, op_valid, sb_error, mOpValid, mErr);
      end
      if (mOpValid) begin
        checks++;
        if (op_a !== mOpA || op_b !== mOpB || op_rd !== mOpRd || op_rd_we !== mOpWe) begin
          errors++;
          $display("FAIL rand_ops: cycle %0d got a=%h b=%h rd=%0d we=%b expected %h/%h/%0d/%b",
                   cyc, op_a, op_b, op_rd, op_rd_we, mOpA, mOpB, mOpRd, mOpWe);
        end
      end
      advance();
    end
    setIssue(0, 0, 0, 0, 0);
    setWb(0, 0, '0);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    for (int i = 0; i < 32; i++) rfMem[i] = 32'(i) * 32'h0101_0101;
    test_reset();
    test_basic_fetch();
    test_raw_bypass();
    test_r0_zero();
    test_pending_limit();
    test_back_to_back();
    test_stray_wb_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
